// File: rtl/send_ctrl_pkg.sv
// Shared constants, types and decode helpers for the send-side sequencer.
// Step and enable indices are bit positions within the 6-bit step and enable vectors.
package send_ctrl_pkg;

    localparam int NUM_STEPS = 6;

    typedef logic [2:0] step_t;
    typedef logic [5:0] en_vec_t;
    typedef logic [NUM_STEPS-1:0] seq_vec_t;

    localparam step_t S1 = 3'd0;
    localparam step_t S2 = 3'd1;
    localparam step_t S3 = 3'd2;
    localparam step_t S4 = 3'd3;
    localparam step_t S5 = 3'd4;
    localparam step_t S6 = 3'd5;

    localparam logic [2:0] EN_IAR = 3'd0;
    localparam logic [2:0] EN_RAM = 3'd1;
    localparam logic [2:0] EN_ACC = 3'd2;
    localparam logic [2:0] EN_ALU = 3'd3;
    localparam logic [2:0] EN_RA  = 3'd4;
    localparam logic [2:0] EN_RB  = 3'd5;

    typedef enum logic [3:0] {
        I_NOP, I_CPT, I_LD, I_ST, I_DATA, I_JMPR, I_JMP, I_JCON, I_CLR, I_DISP, I_HLT
    } instr_e;

    typedef enum logic [0:0] { ST_RUN, ST_HALT } ctrl_state_e;

    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

    function automatic logic multi_hot10(input logic [9:0] v);
        return (v & (v - 10'd1)) != 10'd0;
    endfunction

    function automatic en_vec_t en_bit(input logic [2:0] idx);
        en_vec_t v;
        v = 6'd1 << idx;
        return v;
    endfunction

    // Lines are {HLT,DISP,CLR,JCON,JMP,JMPR,DATA,ST,LD,cpt}; zero or multiple lines fold to NOP.
    function automatic instr_e decode_instr(input logic [9:0] lines);
        instr_e r;
        case (lines)
            10'b00_0000_0001: r = I_CPT;
            10'b00_0000_0010: r = I_LD;
            10'b00_0000_0100: r = I_ST;
            10'b00_0000_1000: r = I_DATA;
            10'b00_0001_0000: r = I_JMPR;
            10'b00_0010_0000: r = I_JMP;
            10'b00_0100_0000: r = I_JCON;
            10'b00_1000_0000: r = I_CLR;
            10'b01_0000_0000: r = I_DISP;
            10'b10_0000_0000: r = I_HLT;
            default:          r = I_NOP;
        endcase
        return r;
    endfunction

    function automatic step_t step_index(input seq_vec_t v);
        step_t r;
        case (v)
            6'b000001: r = S1;
            6'b000010: r = S2;
            6'b000100: r = S3;
            6'b001000: r = S4;
            6'b010000: r = S5;
            6'b100000: r = S6;
            default:   r = S1;
        endcase
        return r;
    endfunction

    function automatic step_t last_step(input instr_e ins);
        step_t r;
        case (ins)
            I_LD, I_ST, I_JMP:     r = S5;
            I_CPT, I_DATA, I_JCON: r = S6;
            default:               r = S4;
        endcase
        return r;
    endfunction

    // Enables driven during step st; flag only matters for the JCON step-6 RAM read.
    function automatic en_vec_t step_enables(input instr_e ins, input step_t st, input logic flag);
        en_vec_t r;
        r = 6'd0;
        case (st)
            S1: r = en_bit(EN_IAR);
            S2: r = en_bit(EN_RAM);
            S3: r = en_bit(EN_ACC);
            S4: begin
                case (ins)
                    I_CPT, I_JMPR, I_DISP:  r = en_bit(EN_RB);
                    I_LD, I_ST:             r = en_bit(EN_RA);
                    I_DATA, I_JMP, I_JCON:  r = en_bit(EN_IAR);
                    default:                r = 6'd0;
                endcase
            end
            S5: begin
                case (ins)
                    I_CPT:               r = en_bit(EN_ALU);
                    I_LD, I_DATA, I_JMP: r = en_bit(EN_RAM);
                    I_ST:                r = en_bit(EN_RB);
                    I_JCON:              r = en_bit(EN_ACC);
                    default:             r = 6'd0;
                endcase
            end
            S6: begin
                case (ins)
                    I_CPT, I_DATA: r = en_bit(EN_ACC);
                    I_JCON:        r = flag ? en_bit(EN_RAM) : 6'd0;
                    default:       r = 6'd0;
                endcase
            end
            default: r = 6'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/send_control_step_ring.sv
// One-hot step register: hold has priority over restart, restart over advance.
module step_ring
    import send_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     advance,
    input  logic     restart,
    input  logic     hold,
    output seq_vec_t seq
);

    seq_vec_t seq_r;

    // Step ring register; advance rotates the single hot bit to the next step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_r <= 6'b000001;
        end else if (hold) begin
            seq_r <= seq_r;
        end else if (restart) begin
            seq_r <= 6'b000001;
        end else if (advance) begin
            seq_r <= {seq_r[4:0], seq_r[5]};
        end else begin
            seq_r <= seq_r;
        end
    end

    assign seq = seq_r;

endmodule

// File: rtl/send_control.sv
// Send-side instruction sequencer: steps 1..6 with registered bus drive enables.
// Optional sticky decode/step error output is enabled by defining SEND_CTRL_CHECK_EN.
module send_control
    import send_ctrl_pkg::*;
(
    input  logic       Oclk,
    input  logic       rst_n,
    input  logic       cpt,
    input  logic       LD,
    input  logic       ST,
    input  logic       DATA,
    input  logic       JMPR,
    input  logic       JMP,
    input  logic       JCON,
    input  logic       CLR,
    input  logic       DISP,
    input  logic       HLT,
    input  logic       flag_ok,
    output logic [5:0] seq,
    output logic       OIAR,
    output logic       ORAM,
    output logic       OACC,
    output logic       OALU,
    output logic       ORA,
    output logic       ORB,
    output logic       halted
`ifdef SEND_CTRL_CHECK_EN
    ,
    output logic       bus_err
`endif
);

    ctrl_state_e state_r, state_nxt;
    en_vec_t     en_r, en_nxt;
    logic        fresh_r;
    logic        advance_s, restart_s, hold_s;
    seq_vec_t    seq_s;
    logic [9:0]  lines_s;
    instr_e      instr_s;
    step_t       cur_step_s;

    assign lines_s = {HLT, DISP, CLR, JCON, JMP, JMPR, DATA, ST, LD, cpt};
    assign instr_s = decode_instr(lines_s);

    step_ring u_ring (
        .clk     (Oclk),
        .rst_n   (rst_n),
        .advance (advance_s),
        .restart (restart_s),
        .hold    (hold_s),
        .seq     (seq_s)
    );

    // Next step and the enables that go with it, loaded together on the same edge.
    always_comb begin
        state_nxt  = state_r;
        en_nxt     = 6'd0;
        advance_s  = 1'b0;
        restart_s  = 1'b0;
        hold_s     = 1'b0;
        cur_step_s = step_index(seq_s);
        case (state_r)
            ST_RUN: begin
                if (!is_onehot6(seq_s)) begin
                    restart_s = 1'b1;
                    en_nxt    = step_enables(I_NOP, S1, 1'b0);
                end else if (seq_s[S3] && (instr_s == I_HLT)) begin
                    advance_s = 1'b1;
                    state_nxt = ST_HALT;
                end else if (cur_step_s == last_step(instr_s)) begin
                    restart_s = 1'b1;
                    en_nxt    = step_enables(I_NOP, S1, 1'b0);
                end else begin
                    advance_s = 1'b1;
                    en_nxt    = step_enables(instr_s, cur_step_s + 3'd1, flag_ok);
                end
            end
            ST_HALT: begin
                hold_s = 1'b1;
            end
            default: begin
                state_nxt = ST_RUN;
                restart_s = 1'b1;
                en_nxt    = step_enables(I_NOP, S1, 1'b0);
            end
        endcase
    end

    // Control state and enable registers; fresh_r marks the first seq1 after reset.
    always_ff @(posedge Oclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            en_r    <= 6'd0;
            fresh_r <= 1'b1;
        end else begin
            state_r <= state_nxt;
            en_r    <= en_nxt;
            fresh_r <= 1'b0;
        end
    end

`ifdef SEND_CTRL_CHECK_EN
    logic err_r;

    // Sticky error: illegal multi-line decode entering seq4, or a corrupted step ring.
    always_ff @(posedge Oclk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (((state_r == ST_RUN) && seq_s[S3] && multi_hot10(lines_s)) || !is_onehot6(seq_s)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus_err = err_r;
`endif

    // The seq1 IAR drive after reset comes straight from the reset state, not a load.
    assign OIAR   = en_r[EN_IAR] | (fresh_r & rst_n);
    assign ORAM   = en_r[EN_RAM];
    assign OACC   = en_r[EN_ACC];
    assign OALU   = en_r[EN_ALU];
    assign ORA    = en_r[EN_RA];
    assign ORB    = en_r[EN_RB];
    assign seq    = seq_s;
    assign halted = (state_r == ST_HALT);

endmodule

// File: tb/tb_send_control.sv
// Self-checking bench for send_control: directed vector table, random instructions
// against a queue-based reference model, and hand sequences for halt and async reset.
module tb_send_control;

    logic       Oclk, rst_n, flag_ok;
    logic       cpt, LD, ST, DATA, JMPR, JMP, JCON, CLR, DISP, HLT;
    logic [5:0] seq;
    logic       OIAR, ORAM, OACC, OALU, ORA, ORB, halted;
`ifdef SEND_CTRL_CHECK_EN
    logic       bus_err;
`endif

    int checks = 0;
    int errors = 0;

    send_control dut (
        .Oclk(Oclk), .rst_n(rst_n),
        .cpt(cpt), .LD(LD), .ST(ST), .DATA(DATA), .JMPR(JMPR), .JMP(JMP),
        .JCON(JCON), .CLR(CLR), .DISP(DISP), .HLT(HLT), .flag_ok(flag_ok),
        .seq(seq), .OIAR(OIAR), .ORAM(ORAM), .OACC(OACC), .OALU(OALU),
        .ORA(ORA), .ORB(ORB), .halted(halted)
`ifdef SEND_CTRL_CHECK_EN
        , .bus_err(bus_err)
`endif
    );

    initial Oclk = 1'b0;
    always #5 Oclk = ~Oclk;

    // Enable codes: 0 none, 1 IAR, 2 RAM, 3 ACC, 4 ALU, 5 RA, 6 RB, 7 more than one.
    typedef struct {
        logic [9:0]  lines;
        logic        flag;
        int          len;
        logic [17:0] codes;
    } vec_t;

    vec_t vecs [12];

    function automatic int dut_code();
        logic [5:0] e;
        int n;
        int c;
        e = {ORB, ORA, OALU, OACC, ORAM, OIAR};
        n = 0;
        c = 0;
        for (int i = 0; i < 6; i++) begin
            if (e[i]) begin
                n++;
                c = i + 1;
            end
        end
        return (n > 1) ? 7 : c;
    endfunction

    function automatic logic [17:0] pk(int c1, int c2, int c3, int c4, int c5, int c6);
        return {3'(c6), 3'(c5), 3'(c4), 3'(c3), 3'(c2), 3'(c1)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_lines(input logic [9:0] l);
        {HLT, DISP, CLR, JCON, JMP, JMPR, DATA, ST, LD, cpt} = l;
    endtask

    // Reference: fetch IAR,RAM,ACC then the instruction's own steps, length = queue size.
    task automatic model(input int id, input logic flag, output int len, output logic [17:0] codes);
        int q[$];
        q = {1, 2, 3};
        case (id)
            1: begin q.push_back(6); q.push_back(4); q.push_back(3); end
            2: begin q.push_back(5); q.push_back(2); end
            3: begin q.push_back(5); q.push_back(6); end
            4: begin q.push_back(1); q.push_back(2); q.push_back(3); end
            5: q.push_back(6);
            6: begin q.push_back(1); q.push_back(2); end
            7: begin q.push_back(1); q.push_back(3); q.push_back(flag ? 2 : 0); end
            9: q.push_back(6);
            default: q.push_back(0);
        endcase
        len = q.size();
        codes = 18'd0;
        for (int k = 0; k < len; k++) codes[3*k +: 3] = 3'(q[k]);
    endtask

    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, " rst seq"}, int'(seq), 1);
        chk({tag, " rst enables"}, dut_code(), 0);
        chk({tag, " rst halted"}, int'(halted), 0);
`ifdef SEND_CTRL_CHECK_EN
        chk({tag, " rst bus_err"}, int'(bus_err), 0);
`endif
        @(negedge Oclk);
        chk({tag, " rst held seq"}, int'(seq), 1);
        rst_n = 1'b1;
        #1;
        chk({tag, " release seq"}, int'(seq), 1);
        chk({tag, " release OIAR"}, dut_code(), 1);
    endtask

    // Entry: just after a falling edge with the DUT in seq1.
    task automatic run_instr(input logic [9:0] lines, input logic flag, input int len,
                             input logic [17:0] codes, input string tag, input int abort_step);
        for (int k = 1; k <= len; k++) begin
            if (k < 3) drive_lines(10'($urandom_range(0, 1023)));
            else       drive_lines(lines);
            flag_ok = (k == 5) ? flag : 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("%s seq%0d step", tag, k), int'(seq), 1 << (k - 1));
            chk($sformatf("%s seq%0d enable", tag, k), dut_code(), int'(codes[3*(k-1) +: 3]));
            chk($sformatf("%s seq%0d halted", tag, k), int'(halted), 0);
            if (k == abort_step) begin
                reset_pulse(tag);
                return;
            end
            @(negedge Oclk);
        end
    endtask

    initial begin
        int len;
        logic [17:0] codes;
        logic [9:0] l;
        int id, a, b;
        logic f;

        rst_n = 1'b0;
        flag_ok = 1'b0;
        drive_lines(10'd0);

        vecs[0]  = '{10'b00_0000_0010, 1'b0, 5, pk(1, 2, 3, 5, 2, 0)};
        vecs[1]  = '{10'b00_0000_0100, 1'b0, 5, pk(1, 2, 3, 5, 6, 0)};
        vecs[2]  = '{10'b00_0001_0000, 1'b0, 4, pk(1, 2, 3, 6, 0, 0)};
        vecs[3]  = '{10'b00_1000_0000, 1'b0, 4, pk(1, 2, 3, 0, 0, 0)};
        vecs[4]  = '{10'b00_0000_0001, 1'b0, 6, pk(1, 2, 3, 6, 4, 3)};
        vecs[5]  = '{10'b00_0000_1000, 1'b0, 6, pk(1, 2, 3, 1, 2, 3)};
        vecs[6]  = '{10'b00_0010_0000, 1'b0, 5, pk(1, 2, 3, 1, 2, 0)};
        vecs[7]  = '{10'b00_0100_0000, 1'b1, 6, pk(1, 2, 3, 1, 3, 2)};
        vecs[8]  = '{10'b00_0100_0000, 1'b0, 6, pk(1, 2, 3, 1, 3, 0)};
        vecs[9]  = '{10'b01_0000_0000, 1'b0, 4, pk(1, 2, 3, 6, 0, 0)};
        vecs[10] = '{10'b00_0000_0000, 1'b0, 4, pk(1, 2, 3, 0, 0, 0)};
        vecs[11] = '{10'b00_0000_0110, 1'b0, 4, pk(1, 2, 3, 0, 0, 0)};

        repeat (2) @(negedge Oclk);
        #1;
        chk("reset seq", int'(seq), 1);
        chk("reset enables", dut_code(), 0);
        chk("reset halted", int'(halted), 0);
        @(negedge Oclk);
        rst_n = 1'b1;
        #1;
        chk("release seq", int'(seq), 1);
        chk("release OIAR", dut_code(), 1);

        for (int i = 0; i < 12; i++) begin
`ifdef SEND_CTRL_CHECK_EN
            if (i == 11) chk("bus_err before illegal", int'(bus_err), 0);
`endif
            run_instr(vecs[i].lines, vecs[i].flag, vecs[i].len, vecs[i].codes,
                      $sformatf("vec%0d", i), 0);
        end
`ifdef SEND_CTRL_CHECK_EN
        chk("bus_err after illegal", int'(bus_err), 1);
        run_instr(vecs[0].lines, 1'b0, vecs[0].len, vecs[0].codes, "post-illegal LD", 0);
        chk("bus_err sticky", int'(bus_err), 1);
`endif

        for (int n = 0; n < 40; n++) begin
            id = $urandom_range(0, 10);
            f  = 1'($urandom_range(0, 1));
            l  = 10'd0;
            if (id >= 1 && id <= 9) begin
                l[id - 1] = 1'b1;
            end else if (id == 10) begin
                a = $urandom_range(0, 9);
                b = (a + 1 + $urandom_range(0, 8)) % 10;
                l[a] = 1'b1;
                l[b] = 1'b1;
            end
            model(id, f, len, codes);
            run_instr(l, f, len, codes, $sformatf("rand%0d id%0d", n, id), 0);
        end

        model(4, 1'b0, len, codes);
        run_instr(10'b00_0000_1000, 1'b0, len, codes, "DATA abort", 5);
        model(2, 1'b0, len, codes);
        run_instr(10'b00_0000_0010, 1'b0, len, codes, "LD after abort", 0);

        for (int k = 1; k <= 3; k++) begin
            drive_lines((k < 3) ? 10'($urandom_range(0, 1023)) : 10'b10_0000_0000);
            #1;
            chk($sformatf("halt fetch seq%0d", k), int'(seq), 1 << (k - 1));
            chk($sformatf("halt fetch enable%0d", k), dut_code(), k);
            @(negedge Oclk);
        end
        for (int c = 0; c < 20; c++) begin
            drive_lines(10'($urandom_range(0, 1023)));
            flag_ok = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("halt seq c%0d", c), int'(seq), 8);
            chk($sformatf("halt enables c%0d", c), dut_code(), 0);
            chk($sformatf("halt flag c%0d", c), int'(halted), 1);
            @(negedge Oclk);
        end
        reset_pulse("halt");
        model(5, 1'b0, len, codes);
        run_instr(10'b00_0001_0000, 1'b0, len, codes, "JMPR after halt", 0);
        #1;
        chk("final seq1", int'(seq), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/send_control.md
SEND_CONTROL -- requirements
Module: send_control

Interface
REQ-001 The block SHALL have no parameters; step count is fixed at 6.
REQ-002 Oclk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpt, LD, ST, DATA, JMPR, JMP, JCON, CLR, DISP, HLT  input  1 each  decoded instruction lines from IR, stable from end of step 2 until the instruction completes.
REQ-005 flag_ok  input  1  jump condition met (from FLAGS compare), sampled in step 5 of JCON.
REQ-006 seq  output  6  one-hot step, bit0=seq1 .. bit5=seq6; feeds receive-side strobe logic.
REQ-007 OIAR, ORAM, OACC, OALU, ORA, ORB  output  1 each  bus drive enables for IAR, RAM, ACC, ALU, reg A, reg B.
REQ-008 halted  output  1  processor stopped.

Function
REQ-009 At most one drive enable SHALL be high in any cycle.
REQ-010 Enables SHALL be registered: on the edge entering step k, the enables for step k are loaded; they remain constant for the whole step.
REQ-011 Fetch, all instructions: seq1 OIAR; seq2 ORAM; seq3 OACC.
REQ-012 cpt: seq4 ORB, seq5 OALU, seq6 OACC; ends after seq6.
REQ-013 LD: seq4 ORA, seq5 ORAM; ends after seq5.  ST: seq4 ORA, seq5 ORB; ends after seq5.
REQ-014 DATA: seq4 OIAR, seq5 ORAM, seq6 OACC; ends after seq6.
REQ-015 JMPR: seq4 ORB; ends after seq4.  JMP: seq4 OIAR, seq5 ORAM; ends after seq5.
REQ-016 JCON: seq4 OIAR, seq5 OACC, seq6 ORAM if flag_ok sampled high in seq5, else no enable in seq6; ends after seq6.
REQ-017 CLR: no enable in seq4; ends after seq4.  DISP: seq4 ORB; ends after seq4.
REQ-018 Ending an instruction SHALL return seq to seq1 on the next edge (early termination, no idle steps).
REQ-019 No instruction line high at seq4 (NOP) or more than one high (illegal): seq4 with no enables, then seq1.
REQ-020 HLT high at seq4 (alone): enter halt; seq holds seq4, all enables low, halted=1 until reset; other inputs ignored.
REQ-021 Instruction lines SHALL only be decoded from seq4 onward; changes during seq1-seq3 have no effect.

Reset
REQ-022 rst_n low SHALL immediately force seq=000001, all enables 0, halted=0, error state cleared.
REQ-023 Reset mid-instruction SHALL abandon it; first edge after release advances seq1->seq2 with ORAM=1 (seq1 enables OIAR=1 apply directly out of reset).

Configuration
REQ-024 Macro SEND_CTRL_CHECK_EN: when defined, extra output bus_err (1 bit) SHALL go high sticky on an illegal multi-line decode or any one-hot violation of seq, cleared only by reset; when undefined the port and logic are absent and illegal decodes act as NOP silently.

Structure
REQ-025 Package send_ctrl_pkg SHALL hold step index constants (S1..S6), enable bit indices, and the 6-bit enable vector type.
REQ-026 Sub-module step_ring SHALL implement the one-hot step register with advance, restart-to-seq1 and hold inputs.

Verification
REQ-027 Reset release, LD=1 -> seq 1,2,3,4,5,1; enables OIAR,ORAM,OACC,ORA,ORAM; five cycles per instruction.
REQ-028 JCON with flag_ok=1 then repeat with flag_ok=0 -> seq6 ORAM=1 first time, all enables 0 in seq6 second time; both take 6 cycles.
REQ-029 Sequence JMPR, CLR, cpt back-to-back -> lengths 4, 4, 6 cycles; cpt seq5 OALU=1.
REQ-030 HLT=1 at seq4 -> seq=001000 held for 20 cycles, halted=1, enables 0; rst_n pulse -> seq=000001, halted=0.
REQ-031 LD=ST=1 at seq4 -> NOP (seq4 then seq1); with SEND_CTRL_CHECK_EN bus_err=1 and stays 1 through next clean instruction.
REQ-032 rst_n asserted asynchronously mid-seq5 of DATA -> outputs reset without a clock edge; every cycle checks enable one-hot-or-zero.
